// File: rtl/bcd_seg_scan_pkg.sv
// rtl/bcd_seg_scan_pkg.sv - shared glyph constants, digit types and helpers for the seven-segment scanner
package bcd_seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [3:0] nibble_of(input logic [15:0] value, input digit_idx_t idx);
    logic [3:0] nib;
    nib = value[3:0];
    case (idx)
      2'd0: nib = value[3:0];
      2'd1: nib = value[7:4];
      2'd2: nib = value[11:8];
      2'd3: nib = value[15:12];
      default: nib = value[3:0];
    endcase
    return nib;
  endfunction

  // A digit is a leading zero when it and every more-significant nibble are zero; units never blank.
  function automatic logic leading_zero(input logic [15:0] value, input digit_idx_t idx);
    logic lz;
    lz = 1'b0;
    case (idx)
      2'd3: lz = (value[15:12] == 4'h0);
      2'd2: lz = (value[15:8] == 8'h00);
      2'd1: lz = (value[15:4] == 12'h000);
      default: lz = 1'b0;
    endcase
    return lz;
  endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// rtl/bcd_seg_scan_if.sv - score input and display pin bundle for the seven-segment scanner
interface bcd_seg_scan_if;

  logic [15:0] bcd_in;
  logic        blank;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (
    output bcd_in,
    output blank,
    input  an,
    input  seg
  );

  modport slave (
    input  bcd_in,
    input  blank,
    output an,
    output seg
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-low seven-segment glyph
module bcd_to_seg7
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Codes A-F are not valid BCD and show a dash rather than hex letters.
  always_comb begin
    glyph = SEG_DASH;
    case (nibble)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - 4-digit multiplexed seven-segment driver; SEG_LZB_EN enables leading-zero blanking
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int         SCAN_DIV = 100000,
  parameter int         DIV_W    = 17,
  parameter logic [3:0] DP_MASK  = 4'b0000
) (
  input  logic          clk,
  input  logic          rst,
  bcd_seg_scan_if.slave bus
);

  logic [DIV_W-1:0] prescaler;
  digit_idx_t       index;
  logic [15:0]      shadow;
  logic [3:0]       an_q;
  logic [7:0]       seg_q;

  logic             tick;
  logic             frame_end;
  logic             suppress;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_glyph;

  assign tick       = (prescaler == DIV_W'(SCAN_DIV - 1));
  assign frame_end  = tick && (index == 2'd3);
  assign cur_nibble = nibble_of(shadow, index);

  // Blanking looks only at the frame snapshot so a digit cannot flicker on mid-frame score changes.
`ifdef SEG_LZB_EN
  assign suppress = leading_zero(shadow, index);
`else
  assign suppress = 1'b0;
`endif

  bcd_to_seg7 u_decode (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      index     <= '0;
      shadow    <= 16'h0000;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        index <= index + 2'd1;
      end
      if (frame_end) begin
        shadow <= bus.bcd_in;
      end
      // blank only gates the pins; the scan keeps its place so release resumes mid-frame.
      if (bus.blank || suppress) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
      end else begin
        an_q  <= ~(4'b0001 << index);
        seg_q <= {~DP_MASK[index], cur_glyph};
      end
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule
